balanced_data_rx: RTL

BALANCED_DATA_RX -- requirements
Module: balanced_data_rx

---
 rtl/balanced_data_rx.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/balanced_data_rx.sv
// ---------------------------------------------------------------------------
// balanced_data_rx
//   Manchester (balanced) serial receiver for LED words. The line is
//   synchronised into clk, and a cell counter separates mid-cell data edges
//   from cell-boundary edges. Words are assembled MSB first.
//
//   Optional feature macro: RX_PARITY_EN
//     When defined, one odd-parity bit follows each word on the line.
//     A parity mismatch raises frame_err in place of data_valid.
//
// Parameters
//   DATA_WIDTH  : bits per LED word (8..32)
//   HALF_PERIOD : clk cycles per half bit cell (even, >= 4)
//
// Ports
//   clk         : system clock, rising edge
//   globalReset : asynchronous active-high reset
//   balancedCLK : Manchester line, asynchronous to clk
//   idle        : line-idle flag from the upstream detector (clk domain)
//   data_out    : last complete word
//   data_valid  : one-cycle pulse when data_out updates
//   frame_err   : one-cycle pulse on a framing or parity error
//   busy        : high while receiving a frame
//   word_cnt    : words accepted in the current frame, saturates at 255
// ---------------------------------------------------------------------------
module balanced_data_rx #(
    parameter int DATA_WIDTH  = 24,
    parameter int HALF_PERIOD = 4
) (
    input  logic                  clk,
    input  logic                  globalReset,
    input  logic                  balancedCLK,
    input  logic                  idle,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  busy,
    output logic [7:0]            word_cnt
);

    localparam int ACCEPT_MIN = (3 * HALF_PERIOD) / 2 - 1;
    localparam int TIMEOUT    = 3 * HALF_PERIOD;
    localparam int CNT_W      = $clog2(TIMEOUT);
`ifdef RX_PARITY_EN
    localparam int LINE_BITS  = DATA_WIDTH + 1;
    localparam int SHIFT_W    = DATA_WIDTH;
`else
    localparam int LINE_BITS  = DATA_WIDTH;
    localparam int SHIFT_W    = DATA_WIDTH - 1;
`endif
    localparam int IDX_W      = $clog2(LINE_BITS);

    localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(ACCEPT_MIN);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(LINE_BITS - 1);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        ARMED,
        RECEIVE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_s1;
    logic                  r_s2;
    logic                  r_s3;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [SHIFT_W-1:0]    r_shift;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic                  r_frame_err;
    logic [7:0]            r_word_cnt;

    logic                  w_edge;
    logic                  w_start;
    logic                  w_accept;
    logic                  w_word_ok;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_edge = r_s2 ^ r_s3;

`ifdef RX_PARITY_EN
    // Data bits are complete in the shift register; r_s2 is the parity bit.
    assign w_word = r_shift;
`else
    // The final data bit is still on r_s2 when the word completes.
    assign w_word = {r_shift, r_s2};
`endif

    // Line synchroniser plus history flop for edge detection.
    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= balancedCLK;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            r_state <= WAIT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Priority inside RECEIVE: idle, then accepted edge, then timeout.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_accept     = 1'b0;
        w_word_ok    = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            WAIT_IDLE: begin
                if (idle) begin
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                if (w_edge) begin
                    w_state_next = RECEIVE;
                    w_start      = 1'b1;
                end
            end
            RECEIVE: begin
                if (idle) begin
                    w_state_next = ARMED;
                    w_err        = (r_bit_idx != '0);
                end else if (w_edge && (r_cnt >= CNT_ACCEPT)) begin
                    w_accept = 1'b1;
                    if (r_bit_idx == IDX_LAST) begin
`ifdef RX_PARITY_EN
                        // Odd parity across data plus parity bit.
                        if ((^r_shift) ^ r_s2) begin
                            w_word_ok = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
`else
                        w_word_ok = 1'b1;
`endif
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = WAIT_IDLE;
                    w_err        = 1'b1;
                end
            end
            default: begin
                w_state_next = WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_word_cnt   <= '0;
        end else begin
            r_data_valid <= w_word_ok;
            r_frame_err  <= w_err;

            if (w_word_ok) begin
                r_data_out <= w_word;
            end

            if (w_start || w_accept) begin
                r_shift <= {r_shift[SHIFT_W-2:0], r_s2};
            end

            if (w_state_next != RECEIVE) begin
                r_bit_idx <= '0;
            end else if (w_start) begin
                r_bit_idx <= IDX_W'(1);
            end else if (w_accept) begin
                r_bit_idx <= (r_bit_idx == IDX_LAST) ? '0 : r_bit_idx + 1'b1;
            end

            if ((w_state_next != RECEIVE) || w_start || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_start) begin
                r_word_cnt <= '0;
            end else if (w_word_ok && (r_word_cnt != 8'hFF)) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state == RECEIVE);
    assign word_cnt   = r_word_cnt;

endmodule
